// File: rtl/unidade_controle_rodadas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidade_controle_rodadas_pkg                                               |
// | State codes shared by the round controller, datapath and display decoder. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package unidade_controle_rodadas_pkg;

    localparam logic [3:0] ST_INICIAL        = 4'h0;
    localparam logic [3:0] ST_PREPARACAO     = 4'h1;
    localparam logic [3:0] ST_ESPERA         = 4'h2;
    localparam logic [3:0] ST_REGISTRA       = 4'h3;
    localparam logic [3:0] ST_COMPARA        = 4'h4;
    localparam logic [3:0] ST_PROXIMA        = 4'h5;
    localparam logic [3:0] ST_FIM_RODADA     = 4'h6;
    localparam logic [3:0] ST_PROXIMA_RODADA = 4'h7;
    localparam logic [3:0] ST_FINAL_ACERTO   = 4'hA;
    localparam logic [3:0] ST_FINAL_TIMEOUT  = 4'hC;
    localparam logic [3:0] ST_FINAL_ERRO     = 4'hE;
    localparam logic [3:0] DB_ESTADO_ILEGAL  = 4'h9;

    function automatic logic estado_final(input logic [3:0] e);
        return (e == ST_FINAL_ACERTO) || (e == ST_FINAL_ERRO) || (e == ST_FINAL_TIMEOUT);
    endfunction

    function automatic logic estado_legal(input logic [3:0] e);
        return (e <= ST_PROXIMA_RODADA) || estado_final(e);
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_m_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | contador_m_param                                                           |
// | Modulo-M up counter with synchronous clear and terminal-count flag.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module contador_m_param #(
    parameter int M = 16,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (zera) begin
            Q <= '0;
        end else if (conta) begin
            if (Q == N'(M - 1)) begin
                Q <= '0;
            end else begin
                Q <= Q + N'(1);
            end
        end
    end

    assign fim = (Q == N'(M - 1));

endmodule
`default_nettype wire

// File: rtl/unidade_controle_rodadas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidade_controle_rodadas                                                   |
// | Round-based memory-game controller with address/round counters and timer. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int N_JOGADAS      = 16,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int ADDR_W         = $clog2(N_JOGADAS),
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic              igual,
    input  logic              modo,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] rodada,
    output logic              registraR,
    output logic              zeraR,
    output logic              acertou,
    output logic              errou,
    output logic              errou_timeout,
    output logic              pronto,
    output logic [3:0]        db_estado,
    output logic              db_timeout
);

    logic [3:0]       estado_q, estado_d;
    logic             modo_q;
    logic [TMR_W-1:0] timer_q;
    logic             timer_fim, rodada_fim, endereco_fim_unused;
    logic             entra_prep;
    logic             zera_end, conta_end, zera_rod, conta_rod, zera_tmr, conta_tmr;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_INICIAL:        if (iniciar) estado_d = ST_PREPARACAO;
            ST_PREPARACAO:     estado_d = ST_ESPERA;
            ST_ESPERA: begin
                if (jogada)                    estado_d = ST_REGISTRA;
                else if (modo_q && timer_fim)  estado_d = ST_FINAL_TIMEOUT;
            end
            ST_REGISTRA:       estado_d = ST_COMPARA;
            ST_COMPARA: begin
                if (!igual)                    estado_d = ST_FINAL_ERRO;
                else if (endereco == rodada)   estado_d = ST_FIM_RODADA;
                else                           estado_d = ST_PROXIMA;
            end
            ST_PROXIMA:        estado_d = ST_ESPERA;
            ST_FIM_RODADA:     estado_d = rodada_fim ? ST_FINAL_ACERTO : ST_PROXIMA_RODADA;
            ST_PROXIMA_RODADA: estado_d = ST_ESPERA;
            ST_FINAL_ACERTO,
            ST_FINAL_ERRO,
            ST_FINAL_TIMEOUT:  if (iniciar) estado_d = ST_PREPARACAO;
            default:           estado_d = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= ST_INICIAL;
            modo_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == ST_PREPARACAO) begin
                modo_q <= modo;
            end
        end
    end

    // Counters clear on the edge entering preparacao so the display reads 0 there.
    assign entra_prep = (estado_d == ST_PREPARACAO) || (estado_q == ST_PREPARACAO);
    assign zera_end   = entra_prep || (estado_q == ST_PROXIMA_RODADA);
    assign conta_end  = (estado_q == ST_PROXIMA);
    assign zera_rod   = entra_prep;
    assign conta_rod  = (estado_q == ST_PROXIMA_RODADA);
    assign conta_tmr  = modo_q && (estado_q == ST_ESPERA) && (estado_d == ST_ESPERA);
    assign zera_tmr   = !conta_tmr;

    contador_m_param #(.M(N_JOGADAS), .N(ADDR_W)) u_cont_endereco (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (zera_end),
        .conta   (conta_end),
        .Q       (endereco),
        .fim     (endereco_fim_unused)
    );

    contador_m_param #(.M(N_JOGADAS), .N(ADDR_W)) u_cont_rodada (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (zera_rod),
        .conta   (conta_rod),
        .Q       (rodada),
        .fim     (rodada_fim)
    );

    contador_m_param #(.M(TIMEOUT_CYCLES), .N(TMR_W)) u_cont_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (zera_tmr),
        .conta   (conta_tmr),
        .Q       (timer_q),
        .fim     (timer_fim)
    );

    assign zeraR         = (estado_q == ST_INICIAL) || (estado_q == ST_PREPARACAO);
    assign registraR     = (estado_q == ST_REGISTRA);
    assign acertou       = (estado_q == ST_FINAL_ACERTO);
    assign errou         = (estado_q == ST_FINAL_ERRO) || (estado_q == ST_FINAL_TIMEOUT);
    assign errou_timeout = (estado_q == ST_FINAL_TIMEOUT);
    assign pronto        = estado_final(estado_q);
    assign db_estado     = estado_legal(estado_q) ? estado_q : DB_ESTADO_ILEGAL;
    assign db_timeout    = (estado_q == ST_ESPERA) && modo_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_rodadas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_unidade_controle_rodadas                                                |
// | Game-level reference model bench: directed scenarios plus random games.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_unidade_controle_rodadas;

    localparam int N = 4;
    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       modo = 1'b0;
    logic [1:0] endereco, rodada;
    logic       registraR, zeraR, acertou, errou, errou_timeout, pronto;
    logic [3:0] db_estado;
    logic       db_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Game-level model: position in the sequence and outcome (0 playing, 1 won, 2 wrong, 3 timeout)
    int   m_rod, m_end, m_fim;
    logic m_modo;

    unidade_controle_rodadas #(.N_JOGADAS(N), .TIMEOUT_CYCLES(T)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .iniciar       (iniciar),
        .jogada        (jogada),
        .igual         (igual),
        .modo          (modo),
        .endereco      (endereco),
        .rodada        (rodada),
        .registraR     (registraR),
        .zeraR         (zeraR),
        .acertou       (acertou),
        .errou         (errou),
        .errou_timeout (errou_timeout),
        .pronto        (pronto),
        .db_estado     (db_estado),
        .db_timeout    (db_timeout)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] estado_esperado();
        case (m_fim)
            1:       return 4'hA;
            2:       return 4'hE;
            3:       return 4'hC;
            default: return 4'h2;
        endcase
    endfunction

    task automatic verifica_saidas(input string ctx);
        verifica({ctx, ".db_estado"},     db_estado,     estado_esperado());
        verifica({ctx, ".endereco"},      endereco,      m_end);
        verifica({ctx, ".rodada"},        rodada,        m_rod);
        verifica({ctx, ".acertou"},       acertou,       m_fim == 1);
        verifica({ctx, ".errou"},         errou,         m_fim == 2 || m_fim == 3);
        verifica({ctx, ".errou_timeout"}, errou_timeout, m_fim == 3);
        verifica({ctx, ".pronto"},        pronto,        m_fim != 0);
        verifica({ctx, ".zeraR"},         zeraR,         0);
        verifica({ctx, ".registraR"},     registraR,     0);
        verifica({ctx, ".db_timeout"},    db_timeout,    m_fim == 0 && m_modo);
    endtask

    task automatic inicia_jogo(input logic md);
        modo    = md;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        verifica("prep.db_estado", db_estado, 4'h1);
        verifica("prep.zeraR",     zeraR,     1);
        verifica("prep.endereco",  endereco,  0);
        verifica("prep.rodada",    rodada,    0);
        verifica("prep.pronto",    pronto,    0);
        tick();
        m_rod  = 0;
        m_end  = 0;
        m_fim  = 0;
        m_modo = md;
        verifica_saidas("inicio");
    endtask

    // One play from espera after d idle cycles; d >= T with the timer on means no play happens.
    task automatic joga(input logic ig, input int d);
        int lat;
        int exp_lat;
        if (m_modo && d >= T) begin
            repeat (T - 1) tick();
            verifica("pre_timeout.db_estado", db_estado, 4'h2);
            tick();
            m_fim = 3;
            verifica_saidas("timeout");
            return;
        end
        repeat (d) tick();
        verifica("espera.db_estado", db_estado, 4'h2);
        jogada = 1'b1;
        igual  = ig;
        tick();
        jogada = 1'b0;
        verifica("registra.registraR", registraR, 1);
        lat = 1;
        while (!(db_estado == 4'h2 || pronto) && lat < 12) begin
            tick();
            lat++;
        end
        if (!ig) begin
            m_fim   = 2;
            exp_lat = 3;
        end else if (m_end == m_rod) begin
            if (m_rod == N - 1) begin
                m_fim   = 1;
                exp_lat = 4;
            end else begin
                m_rod++;
                m_end   = 0;
                exp_lat = 5;
            end
        end else begin
            m_end++;
            exp_lat = 4;
        end
        verifica("latencia", lat, exp_lat);
        verifica_saidas("jogada");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_rod = 0; m_end = 0; m_fim = 0; m_modo = 1'b0;
        #12;
        verifica("reset.db_estado", db_estado, 4'h0);
        verifica("reset.zeraR",     zeraR,     1);
        verifica("reset.pronto",    pronto,    0);
        verifica("reset.endereco",  endereco,  0);
        verifica("reset.rodada",    rodada,    0);
        iniciar = 1'b1;
        tick();
        verifica("reset_iniciar.db_estado", db_estado, 4'h0);
        iniciar = 1'b0;
        reset_n = 1'b1;
        tick();
        verifica("idle.db_estado", db_estado, 4'h0);

        // Full win without timeout
        inicia_jogo(1'b0);
        for (int r = 0; r < N; r++)
            for (int p = 0; p <= r; p++)
                joga(1'b1, $urandom_range(0, 3));
        verifica("win.acertou",   acertou,   1);
        verifica("win.db_estado", db_estado, 4'hA);
        verifica("win.rodada",    rodada,    3);
        verifica("win.endereco",  endereco,  3);

        // Wrong play at round 2, play 1
        inicia_jogo(1'b0);
        joga(1'b1, 0);
        joga(1'b1, 1); joga(1'b1, 0);
        joga(1'b1, 2); joga(1'b0, 0);
        verifica("erro.errou",         errou,         1);
        verifica("erro.errou_timeout", errou_timeout, 0);
        verifica("erro.db_estado",     db_estado,     4'hE);
        verifica("erro.rodada",        rodada,        2);
        verifica("erro.endereco",      endereco,      1);

        // Restart from final_erro straight into a timeout
        inicia_jogo(1'b1);
        joga(1'b1, T);
        verifica("to.errou_timeout", errou_timeout, 1);
        verifica("to.db_estado",     db_estado,     4'hC);

        // Play in the expiry cycle wins, and the window restarts per play
        inicia_jogo(1'b1);
        joga(1'b1, T - 1);
        joga(1'b1, T - 1);
        joga(1'b1, T - 1);
        joga(1'b1, T);

        // Timeout disabled: long idle stays in espera
        inicia_jogo(1'b0);
        joga(1'b1, 100);
        joga(1'b0, 0);

        // Asynchronous reset while in compara
        inicia_jogo(1'b1);
        joga(1'b1, 0);
        jogada = 1'b1;
        igual  = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        verifica("pre_rst.db_estado", db_estado, 4'h4);
        #2;
        reset_n = 1'b0;
        iniciar = 1'b1;
        #1;
        verifica("rst.db_estado",  db_estado, 4'h0);
        verifica("rst.zeraR",      zeraR,     1);
        verifica("rst.endereco",   endereco,  0);
        verifica("rst.rodada",     rodada,    0);
        verifica("rst.registraR",  registraR, 0);
        verifica("rst.errou",      errou,     0);
        verifica("rst.pronto",     pronto,    0);
        verifica("rst.db_timeout", db_timeout, 0);
        tick();
        verifica("rst_hold.db_estado", db_estado, 4'h0);
        reset_n = 1'b1;
        iniciar = 1'b0;
        tick();
        verifica("rst_rel.db_estado", db_estado, 4'h0);

        // Random games
        for (int g = 0; g < 30; g++) begin
            inicia_jogo(1'($urandom_range(0, 1)));
            while (m_fim == 0) begin
                int d;
                if ($urandom_range(0, 15) == 0) d = $urandom_range(T, T + 3);
                else                            d = $urandom_range(0, T - 1);
                joga(1'($urandom_range(0, 19) != 0), d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
